// File: rtl/ybus_wbuf.sv
// Write-back buffer behind the 64-bit datapath: queues {addr, Y, half} pushes,
// drains them over valid/ready and lets loads snoop pending entries by address.
module ybus_wbuf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 15
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [63:0]                y,
    input  logic                       mode32,
    input  logic                       wr,
    input  logic [AW-1:0]              waddr,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ovf,
    input  logic                       ovf_clr,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [AW-1:0]              m_addr,
    output logic [63:0]                m_data,
    output logic                       m_half,
    input  logic [AW-1:0]              rd_addr,
    output logic                       hit,
    output logic [63:0]                hit_data
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [AW-1:0]    addr_q [DEPTH];
    logic [63:0]      data_q [DEPTH];
    logic [DEPTH-1:0] half_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             empty_q;
    logic             ovf_q;
    logic             pop;
    logic             push;
    logic             drop;
    logic [63:0]      wdata;

    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign pop   = !empty_q && m_ready;
    assign push  = wr && (!full_q || pop);
    assign drop  = wr && full_q && !pop;
    assign wdata = mode32 ? {32'h0, y[31:0]} : y;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointers, occupancy flags and sticky overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Entry storage; cleared on reset so the head and bypass read zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            half_q <= '0;
        end else if (push) begin
            addr_q[wr_ptr_q] <= waddr;
            data_q[wr_ptr_q] <= wdata;
            half_q[wr_ptr_q] <= mode32;
        end
    end

    // Oldest-to-newest scan so the last match (newest push) wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && (addr_q[rd_ptr_q + PW'(i)] == rd_addr)) begin
                hit      = 1'b1;
                hit_data = data_q[rd_ptr_q + PW'(i)];
            end
        end
    end

    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;
    assign ovf     = ovf_q;
    assign m_valid = !empty_q;
    assign m_addr  = addr_q[rd_ptr_q];
    assign m_data  = data_q[rd_ptr_q];
    assign m_half  = half_q[rd_ptr_q];
endmodule

// File: tb/tb_ybus_wbuf.sv
// Bench for ybus_wbuf: directed steps then random traffic against a queue model.
module tb_ybus_wbuf;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 15;

    typedef struct {
        logic [AW-1:0] a;
        logic [63:0]   d;
        logic          h;
    } ent_t;

    logic                       clk = 1'b0;
    logic                       reset_n;
    logic [63:0]                y;
    logic                       mode32;
    logic                       wr;
    logic [AW-1:0]              waddr;
    logic                       full;
    logic                       empty;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       ovf;
    logic                       ovf_clr;
    logic                       m_valid;
    logic                       m_ready;
    logic [AW-1:0]              m_addr;
    logic [63:0]                m_data;
    logic                       m_half;
    logic [AW-1:0]              rd_addr;
    logic                       hit;
    logic [63:0]                hit_data;

    int   checks   = 0;
    int   failures = 0;
    ent_t q[$];
    logic m_ovf = 1'b0;

    ybus_wbuf #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .y(y), .mode32(mode32), .wr(wr),
        .waddr(waddr), .full(full), .empty(empty), .count(count), .ovf(ovf),
        .ovf_clr(ovf_clr), .m_valid(m_valid), .m_ready(m_ready),
        .m_addr(m_addr), .m_data(m_data), .m_half(m_half),
        .rd_addr(rd_addr), .hit(hit), .hit_data(hit_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Newest pending entry with a matching address, searched from the tail.
    task automatic chk_bypass();
        logic        eh = 1'b0;
        logic [63:0] ed = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].a == rd_addr) begin
                eh = 1'b1;
                ed = q[i].d;
                break;
            end
        end
        chk("hit", 64'(hit), 64'(eh));
        chk("hit_data", hit_data, ed);
    endtask

    task automatic chk_state();
        chk("count", 64'(count), 64'(q.size()));
        chk("full", 64'(full), 64'(q.size() == DEPTH));
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("m_valid", 64'(m_valid), 64'(q.size() != 0));
        chk("ovf", 64'(ovf), 64'(m_ovf));
        if (q.size() != 0) begin
            chk("m_addr", 64'(m_addr), 64'(q[0].a));
            chk("m_data", m_data, q[0].d);
            chk("m_half", 64'(m_half), 64'(q[0].h));
        end
    endtask

    // One clock: drive, check the bypass before the edge, advance the model, check state.
    task automatic step(input logic w, input logic [AW-1:0] a, input logic [63:0] d,
                        input logic m32, input logic rdy, input logic clr,
                        input logic [AW-1:0] ra);
        bit   do_pop;
        bit   is_full;
        ent_t e;
        wr = w; waddr = a; y = d; mode32 = m32; m_ready = rdy; ovf_clr = clr; rd_addr = ra;
        #1;
        chk_bypass();
        @(posedge clk);
        do_pop  = (q.size() != 0) && rdy;
        is_full = (q.size() == DEPTH);
        if (do_pop) void'(q.pop_front());
        if (w && (!is_full || do_pop)) begin
            e.a = a;
            e.d = m32 ? {32'h0, d[31:0]} : d;
            e.h = m32;
            q.push_back(e);
        end
        if (w && is_full && !do_pop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        #1;
        chk_state();
    endtask

    task automatic idle(input logic rdy, input logic [AW-1:0] ra);
        step(1'b0, '0, '0, 1'b0, rdy, 1'b0, ra);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1, '0);
        chk("drained_empty", 64'(empty), 64'(1));
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [63:0] d, input logic rdy);
        step(1'b1, a, d, 1'b0, rdy, 1'b0, '0);
    endtask

    initial begin
        reset_n = 1'b0; wr = 1'b0; waddr = '0; y = '0; mode32 = 1'b0;
        m_ready = 1'b0; ovf_clr = 1'b0; rd_addr = '0;
        #13;
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_m_data", m_data, 64'h0);
        chk("rst_m_addr", 64'(m_addr), 64'h0);
        chk("rst_ovf", 64'(ovf), 64'(0));
        chk("rst_hit", 64'(hit), 64'(0));
        chk("rst_hit_data", hit_data, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // First push becomes the head one edge later.
        step(1'b1, 15'h0010, 64'h0123456789ABCDEF, 1'b0, 1'b0, 1'b0, '0);
        chk("first_m_valid", 64'(m_valid), 64'(1));
        chk("first_m_addr", 64'(m_addr), 64'h10);
        chk("first_m_data", m_data, 64'h0123456789ABCDEF);
        chk("first_count", 64'(count), 64'(1));

        // 32-bit push behind a pop of the first entry.
        step(1'b1, 15'h0011, 64'hFFFFFFFF_80000001, 1'b1, 1'b1, 1'b0, '0);
        chk("m32_data", m_data, 64'h00000000_80000001);
        chk("m32_half", 64'(m_half), 64'(1));
        drain();

        // Fill and overflow.
        for (int i = 1; i <= 5; i++) begin
            push(AW'(i), {$urandom, $urandom}, 1'b0);
            if (i == 4) chk("fill_full", 64'(full), 64'(1));
        end
        chk("ovf_set", 64'(ovf), 64'(1));
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", 64'(m_addr), 64'(i));
            idle(1'b1, '0);
        end
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0);
        chk("ovf_clr", 64'(ovf), 64'(0));

        // Full with simultaneous push and pop.
        for (int i = 1; i <= 4; i++) push(AW'(i), {$urandom, $urandom}, 1'b0);
        push(15'd9, 64'h9999, 1'b1);
        chk("pp_head", 64'(m_addr), 64'(2));
        chk("pp_count", 64'(count), 64'(4));
        chk("pp_ovf", 64'(ovf), 64'(0));
        for (int i = 0; i < 3; i++) idle(1'b1, '0);
        chk("wrap_last", 64'(m_addr), 64'(9));
        drain();

        // Bypass: newest matching entry wins.
        push(15'd7, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
        push(15'd3, 64'hBBBB_BBBB_BBBB_BBBB, 1'b0);
        push(15'd7, 64'hCCCC_CCCC_CCCC_CCCC, 1'b0);
        idle(1'b0, 15'd7);
        chk("byp_c", hit_data, 64'hCCCC_CCCC_CCCC_CCCC);
        idle(1'b1, 15'd7);
        rd_addr = 15'd7; #1;
        chk("byp_after_pop", hit_data, 64'hCCCC_CCCC_CCCC_CCCC);
        rd_addr = 15'd5; #1;
        chk("byp_miss_hit", 64'(hit), 64'(0));
        chk("byp_miss_data", hit_data, 64'h0);
        drain();

        // Backpressure stall then a single pop.
        push(15'h0042, 64'h1122334455667788, 1'b0);
        push(15'h0043, 64'h99AA, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b0, '0);
        chk("stall_addr", 64'(m_addr), 64'h42);
        idle(1'b1, '0);
        chk("stall_pop_count", 64'(count), 64'(1));
        drain();

        // Random traffic with a narrow address range to exercise hits and drops.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 60, AW'($urandom_range(0, 7)),
                 {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 10,
                 AW'($urandom_range(0, 7)));
        end

        // Reset in the middle of a drain discards everything.
        for (int i = 0; i < 3; i++) push(AW'(i + 1), {$urandom, $urandom}, 1'b0);
        wr = 1'b0; m_ready = 1'b1; rd_addr = 15'd1;
        @(posedge clk); #2;
        reset_n = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        #1;
        chk("mid_rst_count", 64'(count), 64'(0));
        chk("mid_rst_m_valid", 64'(m_valid), 64'(0));
        chk("mid_rst_m_data", m_data, 64'h0);
        chk("mid_rst_m_addr", 64'(m_addr), 64'h0);
        chk("mid_rst_hit", 64'(hit), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        idle(1'b1, 15'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ybus_wbuf.md
# ybus_wbuf

Write-back buffer directly downstream of the 64-bit datapath. It captures the ALU Y bus result, together with a memory word address, on a microprogram write strobe. Entries queue in a small FIFO and drain to the memory interface over a valid/ready handshake, so the datapath never stalls on a slow memory write. Loads can snoop pending entries through an address-match bypass port.

## Interface
Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- AW, 15, memory word address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- y  in  64  ALU Y bus result.
- mode32  in  1  32-bit mode flag; same meaning as in the datapath.
- wr  in  1  microprogram write strobe: push {waddr, y} this cycle.
- waddr  in  AW  target word address for the push.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  $clog2(DEPTH+1)  occupied entries.
- ovf  out  1  sticky: a push was dropped.
- ovf_clr  in  1  synchronous clear of ovf.
- m_valid  out  1  head entry available; equals !empty.
- m_ready  in  1  memory accepts the head this cycle.
- m_addr  out  AW  head entry address.
- m_data  out  64  head entry data.
- m_half  out  1  head entry was written in 32-bit mode.
- rd_addr  in  AW  bypass probe address.
- hit  out  1  some stored entry matches rd_addr.
- hit_data  out  64  data of the newest matching entry; 0 when !hit.

## Operation
- Storage: DEPTH entries of {addr[AW], data[64], half}. Read pointer and write pointer each count modulo DEPTH. A separate count register runs 0..DEPTH.
- Pop: occurs when m_valid && m_ready. At the edge the read pointer advances by 1 with wrap.
- Push acceptance: wr && (!full || pop).
  - A push into a full buffer is accepted only if a pop happens in the same cycle; count stays DEPTH.
  - Accepted push stores addr=waddr and half=mode32.
  - Stored data: mode32=1 stores {32'b0, y[31:0]}; mode32=0 stores y[63:0].
  - The write pointer advances by 1 with wrap.
- Drop: wr && full && !pop. The entry is discarded, FIFO state is unchanged, and ovf is set at the edge.
- ovf_clr clears ovf. When ovf_clr coincides with a drop, the set wins.
- Count update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Bypass (combinational):
  - Scans the valid entries, from head through tail-1.
  - hit=1 if any entry addr == rd_addr.
  - hit_data comes from the most recently pushed match.
  - A push in the current cycle is not visible to the bypass until the next cycle.
  - The entry being popped this cycle still counts as valid this cycle.
- The head outputs m_addr, m_data and m_half are driven directly from registered storage at the read pointer. They remain stable while m_valid && !m_ready.

## Timing
- Reset (asynchronous assert, synchronous release):
  - pointers=0, count=0, empty=1, full=0, ovf=0, m_valid=0.
  - All storage is cleared to 0, so m_addr=0, m_data=0, m_half=0, hit=0, hit_data=0.
  - Reset mid-drain discards all entries; no partial pop occurs.
- Push-to-visible latency is 1 cycle. wr sampled at edge N gives m_valid=1 and head data after edge N, if the buffer was empty.
- Throughput: one push and one pop per cycle sustained. A full buffer with a continuous pop accepts one push every cycle without a drop.
- Handshake: m_valid never falls without a pop. The head does not change while m_valid && !m_ready.
- full, empty and count are registered and reflect state after the last edge.
- The bypass path is combinational from rd_addr to hit and hit_data, with no added latency.

## Test plan
- Reset then idle: with reset_n=0 the outputs are empty=1, count=0, m_valid=0, m_data=0 and ovf=0. Release reset with m_ready=0, push addr=0x0010, y=0x0123456789ABCDEF, mode32=0. Required: after 1 edge, m_valid=1, m_addr=0x0010, m_data=0x0123456789ABCDEF, m_half=0, count=1.
- 32-bit mode: push y=0xFFFFFFFF_80000001, mode32=1. Required: m_data=0x00000000_80000001, m_half=1.
- Fill and overflow: m_ready=0, 5 pushes to addr 1..5. Required: full=1 after the 4th push; the 5th is dropped and ovf=1. Draining yields addresses 1,2,3,4 in order. After ovf_clr, ovf=0.
- Full with simultaneous push/pop: fill to 4, then assert wr with addr=9 and m_ready=1 in the same cycle. Required: head advances to addr 2, count stays 4, ovf stays 0. Addr 9 drains last, confirming pointer wrap.
- Bypass newest-wins: push addr 7 with data A, addr 3 with data B, addr 7 with data C; probe rd_addr=7. Required: hit=1, hit_data=C. After popping through the first addr-7 entry, the result is still C. Probe rd_addr=5: hit=0, hit_data=0.
- Backpressure stall: with m_valid=1, hold m_ready=0 for 3 cycles. Required: m_addr, m_data and m_half stay constant. Then m_ready=1 for 1 cycle: exactly one pop, count decrements by 1.
